traffic_phase_monitor: RTL and testbench

- Receive-side checker for the traffic light subsystem. It consumes the 8-bit lights bus and the two 7-segment digit buses that the controller/display path drives.
- Decodes the digits back into a countdown value, classifies the light pattern into a phase, and tracks the phase sequence. On every 1 Hz tick it checks that the countdown and the phase order are legal.
- Used on-board as a self-check and in simulation as the scoreboard front end.

---
 rtl/traffic_pkg.sv | 74 +++++++
 rtl/traffic_phase_monitor_if.sv | 32 +++
 rtl/seg7_to_bcd.sv | 30 +++
 rtl/traffic_phase_monitor.sv | 138 +++++++++++++
 tb/tb_traffic_phase_monitor.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light subsystem: phases, light bits,
// 7-segment glyphs and error-flag positions.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_UNKNOWN = 3'd0,
        PH_A_GO    = 3'd1,
        PH_A_LEFT  = 3'd2,
        PH_A_YEL   = 3'd3,
        PH_B_GO    = 3'd4,
        PH_B_LEFT  = 3'd5,
        PH_B_YEL   = 3'd6
    } phase_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } arm_state_t;

    localparam int L_AG = 7;
    localparam int L_AY = 6;
    localparam int L_AR = 5;
    localparam int L_AL = 4;
    localparam int L_BG = 3;
    localparam int L_BY = 2;
    localparam int L_BR = 1;
    localparam int L_BL = 0;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam int ERR_SEQ      = 3;
    localparam int ERR_COUNT    = 2;
    localparam int ERR_SEG      = 1;
    localparam int ERR_CONFLICT = 0;

    // Exactly one go/left/yellow on one approach with red on the other;
    // every other pattern (all off, conflicting greens) is UNKNOWN.
    function automatic phase_t classify(input logic [7:0] l);
        phase_t p;
        p = PH_UNKNOWN;
        if (l == ((8'd1 << L_AG) | (8'd1 << L_BR))) p = PH_A_GO;
        if (l == ((8'd1 << L_AL) | (8'd1 << L_BR))) p = PH_A_LEFT;
        if (l == ((8'd1 << L_AY) | (8'd1 << L_BR))) p = PH_A_YEL;
        if (l == ((8'd1 << L_BG) | (8'd1 << L_AR))) p = PH_B_GO;
        if (l == ((8'd1 << L_BL) | (8'd1 << L_AR))) p = PH_B_LEFT;
        if (l == ((8'd1 << L_BY) | (8'd1 << L_AR))) p = PH_B_YEL;
        return p;
    endfunction

    function automatic phase_t successor(input phase_t p);
        phase_t n;
        case (p)
            PH_A_GO:   n = PH_A_LEFT;
            PH_A_LEFT: n = PH_A_YEL;
            PH_A_YEL:  n = PH_B_GO;
            PH_B_GO:   n = PH_B_LEFT;
            PH_B_LEFT: n = PH_B_YEL;
            PH_B_YEL:  n = PH_A_GO;
            default:   n = PH_UNKNOWN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_monitor_if.sv
// Bus between the lights/display path (master) and the phase monitor (slave).
// tick is a one-cycle enable with no ready: every bus signal is sampled by the
// slave only in the cycle tick = 1, and result signals are valid from the
// following cycle until the next tick (phase_change/err_pulse last one cycle).
interface traffic_phase_monitor_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 tick;
    logic [7:0]           lights;
    logic [7:0]           seg_ones;
    logic [7:0]           seg_tens;
    logic [6:0]           count_value;
    logic                 count_valid;
    logic [2:0]           phase;
    logic                 phase_change;
    logic                 err_pulse;
    logic [3:0]           err_flags;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 dbg_armed;

    modport master (
        output tick, lights, seg_ones, seg_tens,
        input  count_value, count_valid, phase, phase_change,
               err_pulse, err_flags, err_count, dbg_armed
    );

    modport slave (
        input  tick, lights, seg_ones, seg_tens,
        output count_value, count_valid, phase, phase_change,
               err_pulse, err_flags, err_count, dbg_armed
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment glyph decoder; unknown patterns report valid = 0.
module seg7_to_bcd
    import traffic_pkg::*;
(
    input  logic [6:0] seg,
    input  logic       active_low,
    output logic [3:0] digit,
    output logic       valid
);
    logic [6:0] s;

    always_comb begin
        s     = active_low ? ~seg : seg;
        digit = 4'd0;
        valid = 1'b1;
        case (s)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/traffic_phase_monitor.sv
// Checks countdown and phase order of the traffic light outputs on each tick.
module traffic_phase_monitor
    import traffic_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_phase_monitor_if.slave  mon
);
    logic [3:0] ones_digit, tens_digit;
    logic       ones_ok, tens_ok;
    logic       unused_dp;

    assign unused_dp = mon.seg_ones[7] ^ mon.seg_tens[7];

    seg7_to_bcd u_ones (
        .seg        (mon.seg_ones[6:0]),
        .active_low (SEG_ACTIVE_LOW),
        .digit      (ones_digit),
        .valid      (ones_ok)
    );

    seg7_to_bcd u_tens (
        .seg        (mon.seg_tens[6:0]),
        .active_low (SEG_ACTIVE_LOW),
        .digit      (tens_digit),
        .valid      (tens_ok)
    );

    arm_state_t           state_q, state_d;
    phase_t               phase_q, phase_d;
    phase_t               prev_phase_q, prev_phase_d;
    logic [6:0]           prev_count_q, prev_count_d;
    logic [6:0]           count_value_q, count_value_d;
    logic                 count_valid_q, count_valid_d;
    logic                 phase_change_q, phase_change_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [3:0]           err_flags_q, err_flags_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    phase_t     cur_phase;
    logic [6:0] cur_count;
    logic       seg_ok, tick_valid;
    logic [3:0] err_now;

    always_comb begin
        cur_phase = classify(mon.lights);
        cur_count = ({3'd0, tens_digit} * 7'd10) + {3'd0, ones_digit};
        seg_ok    = ones_ok & tens_ok;
        tick_valid = seg_ok && (cur_phase != PH_UNKNOWN);

        state_d        = state_q;
        phase_d        = phase_q;
        prev_phase_d   = prev_phase_q;
        prev_count_d   = prev_count_q;
        count_value_d  = count_value_q;
        count_valid_d  = count_valid_q;
        phase_change_d = 1'b0;
        err_pulse_d    = 1'b0;
        err_flags_d    = err_flags_q;
        err_count_d    = err_count_q;
        err_now        = 4'd0;

        if (mon.tick) begin
            phase_d        = cur_phase;
            phase_change_d = (cur_phase != phase_q);
            count_valid_d  = seg_ok;
            if (seg_ok) count_value_d = cur_count;

            err_now[ERR_SEG]      = !seg_ok;
            err_now[ERR_CONFLICT] = (cur_phase == PH_UNKNOWN);

            if (state_q == ST_ARMED && tick_valid) begin
                if (cur_phase == prev_phase_q) begin
                    // Countdown never wraps inside a phase.
                    if (prev_count_q == 7'd0 || cur_count != prev_count_q - 7'd1)
                        err_now[ERR_COUNT] = 1'b1;
                end else begin
                    if (prev_count_q > 7'd1 || cur_count == 7'd0)
                        err_now[ERR_COUNT] = 1'b1;
                    if (cur_phase != successor(prev_phase_q))
                        err_now[ERR_SEQ] = 1'b1;
                end
            end

            // History follows every valid tick so the monitor resynchronises.
            if (tick_valid) begin
                prev_phase_d = cur_phase;
                prev_count_d = cur_count;
                state_d      = ST_ARMED;
            end else begin
                state_d      = ST_IDLE;
            end

            err_pulse_d = |err_now;
            err_flags_d = err_flags_q | err_now;
            if (|err_now && err_count_q != {ERR_CNT_W{1'b1}})
                err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_UNKNOWN;
            prev_phase_q   <= PH_UNKNOWN;
            prev_count_q   <= 7'd0;
            count_value_q  <= 7'd0;
            count_valid_q  <= 1'b0;
            phase_change_q <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_flags_q    <= 4'd0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            prev_phase_q   <= prev_phase_d;
            prev_count_q   <= prev_count_d;
            count_value_q  <= count_value_d;
            count_valid_q  <= count_valid_d;
            phase_change_q <= phase_change_d;
            err_pulse_q    <= err_pulse_d;
            err_flags_q    <= err_flags_d;
            err_count_q    <= err_count_d;
        end
    end

    assign mon.count_value  = count_value_q;
    assign mon.count_valid  = count_valid_q;
    assign mon.phase        = phase_q;
    assign mon.phase_change = phase_change_q;
    assign mon.err_pulse    = err_pulse_q;
    assign mon.err_flags    = err_flags_q;
    assign mon.err_count    = err_count_q;
    assign mon.dbg_armed    = (state_q == ST_ARMED);
endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Directed bench: an active-high and an active-low monitor watch the same
// stimulus, the second one seeing inverted segment buses.
module tb_traffic_phase_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    traffic_phase_monitor_if #(.ERR_CNT_W(8)) bus0 ();
    traffic_phase_monitor_if #(.ERR_CNT_W(8)) bus1 ();

    assign bus1.tick     = bus0.tick;
    assign bus1.lights   = bus0.lights;
    assign bus1.seg_ones = ~bus0.seg_ones;
    assign bus1.seg_tens = ~bus0.seg_tens;

    traffic_phase_monitor #(.SEG_ACTIVE_LOW(1'b0), .ERR_CNT_W(8)) dut0 (
        .clk (clk), .rst (rst), .mon (bus0)
    );
    traffic_phase_monitor #(.SEG_ACTIVE_LOW(1'b1), .ERR_CNT_W(8)) dut1 (
        .clk (clk), .rst (rst), .mon (bus1)
    );

    localparam logic [7:0] LT_A_GO   = 8'h82;
    localparam logic [7:0] LT_A_LEFT = 8'h12;
    localparam logic [7:0] LT_A_YEL  = 8'h42;
    localparam logic [7:0] LT_B_GO   = 8'h28;
    localparam logic [7:0] LT_B_LEFT = 8'h21;
    localparam logic [7:0] LT_B_YEL  = 8'h24;

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
            8: return 8'h7F; default: return 8'h6F;
        endcase
    endfunction

    function automatic logic [7:0] ph_lights(input int p);
        case (p)
            1: return LT_A_GO;   2: return LT_A_LEFT; 3: return LT_A_YEL;
            4: return LT_B_GO;   5: return LT_B_LEFT; default: return LT_B_YEL;
        endcase
    endfunction

    task automatic do_tick(input logic [7:0] l, input logic [7:0] tens, input logic [7:0] ones);
        @(negedge clk);
        bus0.lights   = l;
        bus0.seg_tens = tens;
        bus0.seg_ones = ones;
        bus0.tick     = 1'b1;
        @(negedge clk);
        bus0.tick     = 1'b0;
    endtask

    task automatic tick_cnt(input logic [7:0] l, input int cnt);
        do_tick(l, glyph(cnt / 10), glyph(cnt % 10));
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_rst();
        n_cmp += 6;
        if (bus0.count_value !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus0.count_value); end
        if (bus0.count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus0.count_valid); end
        if (bus0.phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", bus0.phase); end
        if ({bus0.phase_change, bus0.err_pulse} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {bus0.phase_change, bus0.err_pulse}); end
        if ({bus0.err_flags, bus0.err_count} !== 12'h000) begin n_fail++; $display("FAIL reset_errs: got %h want 000", {bus0.err_flags, bus0.err_count}); end
        if ({bus1.phase, bus1.err_count, bus1.count_valid} !== 12'h000) begin n_fail++; $display("FAIL reset_dut1: got %h want 000", {bus1.phase, bus1.err_count, bus1.count_valid}); end
    endtask

    task automatic test_legal_cycle();
        int starts[7] = '{5, 3, 2, 5, 3, 2, 5};
        logic [2:0] exp_ph;
        pulse_rst();
        for (int s = 0; s < 7; s++) begin
            for (int c = starts[s]; c >= ((s == 6) ? 5 : 1); c--) begin
                exp_q.push_back(3'((s % 6) + 1));
                tick_cnt(ph_lights((s % 6) + 1), c);
                exp_ph = exp_q.pop_front();
                n_cmp += 4;
                if (bus0.phase !== exp_ph) begin n_fail++; $display("FAIL legal_phase: got %0d want %0d", bus0.phase, exp_ph); end
                if (bus0.phase_change !== (c == starts[s])) begin n_fail++; $display("FAIL legal_change: got %b want %b", bus0.phase_change, (c == starts[s])); end
                if (bus0.count_value !== 7'(c) || bus0.count_valid !== 1'b1) begin n_fail++; $display("FAIL legal_count: got %0d/%b want %0d/1", bus0.count_value, bus0.count_valid, c); end
                if (bus0.err_pulse !== 1'b0) begin n_fail++; $display("FAIL legal_err_pulse: got %b want 0", bus0.err_pulse); end
            end
        end
        n_cmp += 3;
        if (bus0.err_flags !== 4'd0 || bus0.err_count !== 8'd0) begin n_fail++; $display("FAIL legal_errs: got %b/%0d want 0000/0", bus0.err_flags, bus0.err_count); end
        if (bus1.err_flags !== 4'd0 || bus1.err_count !== 8'd0) begin n_fail++; $display("FAIL legal_errs_dut1: got %b/%0d want 0000/0", bus1.err_flags, bus1.err_count); end
        if (bus0.dbg_armed !== 1'b1) begin n_fail++; $display("FAIL legal_armed: got %b want 1", bus0.dbg_armed); end
    endtask

    task automatic test_count_skip();
        pulse_rst();
        tick_cnt(LT_A_GO, 5);
        tick_cnt(LT_A_GO, 3);
        n_cmp += 2;
        if (bus0.err_pulse !== 1'b1) begin n_fail++; $display("FAIL skip_pulse: got %b want 1", bus0.err_pulse); end
        if (bus0.err_flags !== 4'b0100 || bus0.err_count !== 8'd1) begin n_fail++; $display("FAIL skip_errs: got %b/%0d want 0100/1", bus0.err_flags, bus0.err_count); end
        @(negedge clk);
        n_cmp++;
        if (bus0.err_pulse !== 1'b0) begin n_fail++; $display("FAIL skip_pulse_width: got %b want 0", bus0.err_pulse); end
        tick_cnt(LT_A_GO, 2);
        n_cmp++;
        if (bus0.err_pulse !== 1'b0 || bus0.err_count !== 8'd1) begin n_fail++; $display("FAIL skip_resync: got %b/%0d want 0/1", bus0.err_pulse, bus0.err_count); end
    endtask

    task automatic test_conflict();
        pulse_rst();
        tick_cnt(LT_A_GO, 5);
        tick_cnt(LT_A_GO, 4);
        tick_cnt(8'b1000_1000, 3);
        n_cmp += 3;
        if (bus0.phase !== 3'd0 || bus0.phase_change !== 1'b1) begin n_fail++; $display("FAIL conflict_phase: got %0d/%b want 0/1", bus0.phase, bus0.phase_change); end
        if (bus0.err_flags !== 4'b0001 || bus0.err_pulse !== 1'b1) begin n_fail++; $display("FAIL conflict_flags: got %b/%b want 0001/1", bus0.err_flags, bus0.err_pulse); end
        if (bus0.dbg_armed !== 1'b0) begin n_fail++; $display("FAIL conflict_armed: got %b want 0", bus0.dbg_armed); end
        tick_cnt(LT_B_GO, 5);
        tick_cnt(LT_B_GO, 4);
        n_cmp += 2;
        if (bus0.err_flags !== 4'b0001 || bus0.err_count !== 8'd1) begin n_fail++; $display("FAIL conflict_rearm: got %b/%0d want 0001/1", bus0.err_flags, bus0.err_count); end
        if (bus0.phase !== 3'd4) begin n_fail++; $display("FAIL conflict_phase_after: got %0d want 4", bus0.phase); end
    endtask

    task automatic test_bad_glyph();
        pulse_rst();
        tick_cnt(LT_A_GO, 9);
        do_tick(LT_A_GO, glyph(0), 8'hFF);
        n_cmp += 2;
        if (bus0.count_value !== 7'd8 || bus0.count_valid !== 1'b1) begin n_fail++; $display("FAIL glyph_dp: got %0d/%b want 8/1", bus0.count_value, bus0.count_valid); end
        if (bus0.err_count !== 8'd0) begin n_fail++; $display("FAIL glyph_dp_err: got %0d want 0", bus0.err_count); end
        do_tick(LT_A_GO, glyph(0), 8'h01);
        n_cmp += 3;
        if (bus0.count_value !== 7'd8 || bus0.count_valid !== 1'b0) begin n_fail++; $display("FAIL glyph_bad: got %0d/%b want 8/0", bus0.count_value, bus0.count_valid); end
        if (bus0.err_flags !== 4'b0010 || bus0.err_pulse !== 1'b1) begin n_fail++; $display("FAIL glyph_flags: got %b/%b want 0010/1", bus0.err_flags, bus0.err_pulse); end
        if (bus1.count_value !== 7'd8 || bus1.count_valid !== 1'b0 || bus1.err_flags !== 4'b0010) begin n_fail++; $display("FAIL glyph_bad_dut1: got %0d/%b/%b want 8/0/0010", bus1.count_value, bus1.count_valid, bus1.err_flags); end
        tick_cnt(LT_A_GO, 7);
        n_cmp++;
        if (bus0.count_value !== 7'd7 || bus0.count_valid !== 1'b1 || bus0.err_count !== 8'd1) begin n_fail++; $display("FAIL glyph_recover: got %0d/%b/%0d want 7/1/1", bus0.count_value, bus0.count_valid, bus0.err_count); end
    endtask

    task automatic test_seq_skip();
        pulse_rst();
        tick_cnt(LT_A_GO, 2);
        tick_cnt(LT_A_GO, 1);
        tick_cnt(LT_B_GO, 5);
        n_cmp += 3;
        if (bus0.err_flags !== 4'b1000 || bus0.err_count !== 8'd1) begin n_fail++; $display("FAIL seq_errs: got %b/%0d want 1000/1", bus0.err_flags, bus0.err_count); end
        if (bus0.phase !== 3'd4 || bus0.phase_change !== 1'b1 || bus0.err_pulse !== 1'b1) begin n_fail++; $display("FAIL seq_phase: got %0d/%b/%b want 4/1/1", bus0.phase, bus0.phase_change, bus0.err_pulse); end
        if (bus1.err_flags !== 4'b1000 || bus1.err_count !== 8'd1 || bus1.phase !== 3'd4) begin n_fail++; $display("FAIL seq_dut1: got %b/%0d/%0d want 1000/1/4", bus1.err_flags, bus1.err_count, bus1.phase); end
    endtask

    task automatic test_saturation();
        pulse_rst();
        @(negedge clk);
        bus0.lights   = 8'h00;
        bus0.seg_tens = glyph(0);
        bus0.seg_ones = glyph(1);
        bus0.tick     = 1'b1;
        repeat (260) @(negedge clk);
        bus0.tick = 1'b0;
        n_cmp += 2;
        if (bus0.err_count !== 8'd255 || bus1.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d/%0d want 255/255", bus0.err_count, bus1.err_count); end
        if (bus0.err_flags !== 4'b0001 || bus0.err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_flags: got %b/%b want 0001/1", bus0.err_flags, bus0.err_pulse); end
    endtask

    task automatic test_reset_mid();
        pulse_rst();
        n_cmp += 2;
        if ({bus0.count_value, bus0.count_valid, bus0.phase, bus0.phase_change, bus0.err_pulse} !== 13'd0) begin n_fail++; $display("FAIL mid_rst_outs: got %h want 0", {bus0.count_value, bus0.count_valid, bus0.phase, bus0.phase_change, bus0.err_pulse}); end
        if (bus0.err_flags !== 4'd0 || bus0.err_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_errs: got %b/%0d want 0000/0", bus0.err_flags, bus0.err_count); end
        tick_cnt(LT_A_YEL, 3);
        tick_cnt(LT_A_YEL, 2);
        n_cmp++;
        if (bus0.err_count !== 8'd0 || bus0.phase !== 3'd3) begin n_fail++; $display("FAIL mid_rst_history: got %0d/%0d want 0/3", bus0.err_count, bus0.phase); end
    endtask

    initial begin
        bus0.tick     = 1'b0;
        bus0.lights   = 8'h00;
        bus0.seg_ones = 8'h00;
        bus0.seg_tens = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_legal_cycle();
        test_count_skip();
        test_conflict();
        test_bad_glyph();
        test_seq_skip();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
